prio_encoder_pipe: RTL and testbench

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

---
 rtl/prio_encoder_pipe.sv | 116 +++++++++++
 tb/tb_prio_encoder_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_pipe.sv
// Pipelined priority encoder with a single valid/ready result register.
// RR=0 selects the highest set request bit; RR=1 rotates priority so the
// search starts just above the previously selected index.
// Optional build macro ENC_MULTI_FLAG_EN adds output M, flagging an accepted
// request vector with two or more bits set.
module prio_encoder_pipe #(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Y,
    output logic         Z,
    output logic         out_valid,
`ifdef ENC_MULTI_FLAG_EN
    output logic         M,
`endif
    input  logic         out_ready
);

    // Highest set bit; an all-zero vector encodes as 0.
    function automatic logic [W-1:0] highest_idx(input logic [N-1:0] req);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) idx = W'(i);
        end
        return idx;
    endfunction

    // First set bit at or above last+1, wrapping to the lowest set bit when
    // nothing lies above. Scanning downward leaves the smallest hit in each half.
    function automatic logic [W-1:0] rr_idx(input logic [N-1:0] req,
                                            input logic [W-1:0] last);
        logic [W-1:0] above;
        logic [W-1:0] wrap;
        logic         hit_above;
        above     = '0;
        wrap      = '0;
        hit_above = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    above     = W'(i);
                    hit_above = 1'b1;
                end else begin
                    wrap = W'(i);
                end
            end
        end
        return hit_above ? above : wrap;
    endfunction

    logic         vld_p1;
    logic [W-1:0] y_p1;
    logic         z_p1;
    logic [W-1:0] ptr;
    logic         accept;
    logic         zero_p0;
    logic [W-1:0] sel_p0;
`ifdef ENC_MULTI_FLAG_EN
    logic         m_p1;
    logic         multi_p0;
`endif

    // Handshake: the result register may be refilled whenever it is empty or
    // being drained in the same cycle, so streaming has no bubbles.
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // ---- stage p0: combinational encode of the incoming request ----
    // Select the index for the configured arbitration mode.
    always_comb begin
        zero_p0 = (A == '0);
        sel_p0  = (RR != 0) ? rr_idx(A, ptr) : highest_idx(A);
`ifdef ENC_MULTI_FLAG_EN
        multi_p0 = ((A & (A - N'(1))) != '0);
`endif
    end

    // ---- stage p1: result register and round-robin pointer ----
    // Load on accept, drain on consume, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            y_p1   <= '0;
            z_p1   <= 1'b0;
            ptr    <= W'(N - 1);
`ifdef ENC_MULTI_FLAG_EN
            m_p1   <= 1'b0;
`endif
        end else if (accept) begin
            vld_p1 <= 1'b1;
            y_p1   <= zero_p0 ? '0 : sel_p0;
            z_p1   <= zero_p0;
`ifdef ENC_MULTI_FLAG_EN
            m_p1   <= multi_p0;
`endif
            if (!zero_p0) ptr <= sel_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign Y         = y_p1;
    assign Z         = z_p1;
`ifdef ENC_MULTI_FLAG_EN
    assign M         = m_p1;
`endif

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench for prio_encoder_pipe: three instances cover fixed
// priority (N=8), round-robin (N=8) and round-robin with N=5.
module tb_prio_encoder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0][7:0] av;
    logic [4:0]      a5;
    logic [2:0]      iv, ir, zv, ov, orr;
    logic [2:0][2:0] yv;
`ifdef ENC_MULTI_FLAG_EN
    logic [2:0]      mv;
`endif

    prio_encoder_pipe #(.N(8), .RR(0)) u0 (
        .clk(clk), .rst(rst), .A(av[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .Y(yv[0]), .Z(zv[0]), .out_valid(ov[0]),
`ifdef ENC_MULTI_FLAG_EN
        .M(mv[0]),
`endif
        .out_ready(orr[0]));

    prio_encoder_pipe #(.N(8), .RR(1)) u1 (
        .clk(clk), .rst(rst), .A(av[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .Y(yv[1]), .Z(zv[1]), .out_valid(ov[1]),
`ifdef ENC_MULTI_FLAG_EN
        .M(mv[1]),
`endif
        .out_ready(orr[1]));

    prio_encoder_pipe #(.N(5), .RR(1)) u2 (
        .clk(clk), .rst(rst), .A(a5), .in_valid(iv[2]), .in_ready(ir[2]),
        .Y(yv[2]), .Z(zv[2]), .out_valid(ov[2]),
`ifdef ENC_MULTI_FLAG_EN
        .M(mv[2]),
`endif
        .out_ready(orr[2]));

    typedef struct packed {
        logic [2:0] y;
        logic       z;
        logic       m;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Drive one request to instance d (caller sits between edges), wait for
    // acceptance, record the hand-computed result and confirm one-cycle latency.
    task automatic send(input int d, input logic [7:0] a, input int y,
                        input bit z, input bit m);
        int   waited;
        exp_t e;
        waited = 0;
        case (d)
            0:       av[0] = a;
            1:       av[1] = a;
            default: a5 = a[4:0];
        endcase
        iv[d] = 1'b1;
        #1;
        while (!ir[d] && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("accept_within_budget", int'(waited < 50), 1);
        @(posedge clk);
        e.y = 3'(y);
        e.z = z;
        e.m = m;
        push_exp(d, e);
        @(negedge clk);
        #1;
        chk("out_valid_after_accept", int'(ov[d]), 1);
    endtask

    task automatic idle();
        iv = '0;
        @(negedge clk);
        orr = '1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every handshake seen mid-cycle is consumed at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && orr[d]) begin
                    exp_t e;
                    bit   ok;
                    pop_exp(d, e, ok);
                    chk("scoreboard_has_entry", int'(ok), 1);
                    if (ok) begin
                        chk($sformatf("Y_dut%0d", d), int'(yv[d]), int'(e.y));
                        chk($sformatf("Z_dut%0d", d), int'(zv[d]), int'(e.z));
`ifdef ENC_MULTI_FLAG_EN
                        chk($sformatf("M_dut%0d", d), int'(mv[d]), int'(e.m));
`endif
                    end
                    if (d == 2) chk("Y_n5_in_range", int'(yv[2] <= 3'd4), 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iv  = '0;
        orr = '1;
        av  = '0;
        a5  = '0;
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_valid", int'(ov[d]), 0);
            chk("reset_Y", int'(yv[d]), 0);
            chk("reset_Z", int'(zv[d]), 0);
            chk("reset_in_ready", int'(ir[d]), 1);
        end
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority: one-hot walk, then mixed, zero and extreme bits.
        for (int i = 0; i < 8; i++) send(0, 8'(1 << i), i, 1'b0, 1'b0);
        send(0, 8'b0101_0010, 6, 1'b0, 1'b1);
        send(0, 8'h00,        0, 1'b1, 1'b0);
        send(0, 8'b1000_0001, 7, 1'b0, 1'b1);
        idle();

        // Round-robin N=8: wrap, then zero request leaves the pointer alone.
        send(1, 8'b1001_0010, 1, 1'b0, 1'b1);
        send(1, 8'b1001_0010, 4, 1'b0, 1'b1);
        send(1, 8'b1001_0010, 7, 1'b0, 1'b1);
        send(1, 8'b1001_0010, 1, 1'b0, 1'b1);
        send(1, 8'h00,        0, 1'b1, 1'b0);
        send(1, 8'b1001_0010, 4, 1'b0, 1'b1);
        idle();

        // Round-robin N=5 (non power of two).
        send(2, 8'b0001_0001, 0, 1'b0, 1'b1);
        send(2, 8'b0001_0001, 4, 1'b0, 1'b1);
        send(2, 8'b0001_0001, 0, 1'b0, 1'b1);
        send(2, 8'b0001_0000, 4, 1'b0, 1'b0);
        idle();

        // Backpressure: result held three cycles, second request refused.
        orr[0] = 1'b0;
        send(0, 8'h40, 6, 1'b0, 1'b0);
        fork
            send(0, 8'h01, 0, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 3; k++) begin
                    #2;
                    chk("stall_Y_held", int'(yv[0]), 6);
                    chk("stall_out_valid", int'(ov[0]), 1);
                    chk("stall_in_ready", int'(ir[0]), 0);
                    @(negedge clk);
                end
                orr[0] = 1'b1;
            end
        join
        idle();

        // Asynchronous reset during a stalled transfer on the RR instance.
        orr[1] = 1'b0;
        send(1, 8'h04, 2, 1'b0, 1'b0);
        #1;
        chk("pre_reset_out_valid", int'(ov[1]), 1);
        chk("pre_reset_Y", int'(yv[1]), 2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_out_valid", int'(ov[1]), 0);
        chk("async_reset_Y", int'(yv[1]), 0);
        chk("async_reset_Z", int'(zv[1]), 0);
        q1.delete();
        @(negedge clk);
        rst    = 1'b0;
        orr[1] = 1'b1;
        send(1, 8'b1001_0010, 1, 1'b0, 1'b1);
        idle();

        chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
